// File: rtl/calc_pkg.sv
// Shared calculator types plus the constants and helpers used by the ALU
// arbiter and its tag FIFO.
package calc_pkg;

  typedef logic [15:0] num_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  localparam int NumAluRequesters  = 2;
  localparam int MaxAluOutstanding = 2;

  typedef logic [$clog2(NumAluRequesters)-1:0] req_id_t;

  // Index width that never collapses to zero bits, so a 1-entry structure
  // still gets a legal 1-bit pointer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_checker.sv
// Protocol checks for the ALU arbiter: a locked requester must keep its
// request raised, and at most one requester is acknowledged per cycle.
module alu_arbiter_checker #(
  parameter int NumReq = 2,
  parameter int IdxW   = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              lock_i,
  input logic [IdxW-1:0]   lock_idx_i,
  input logic [NumReq-1:0] req_valid_i,
  input logic [NumReq-1:0] req_ready_i
);

  a_locked_req_held: assert property (
    @(posedge clk_i) disable iff (!rst_ni) lock_i |-> req_valid_i[lock_idx_i]
  ) else $error("locked requester dropped req_valid_i");

  a_single_ready: assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_i)
  ) else $error("more than one req_ready_o bit set");

endmodule

// File: rtl/tag_fifo.sv
// Small in-order FIFO holding the requester tag of every accepted ALU
// operation whose result has not yet come back.
module tag_fifo
  import calc_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int PtrW = idx_width(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [CntW-1:0]  count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign full_o    = (count_r == CntW'(Depth));
  assign empty_o   = (count_r == {CntW{1'b0}});
  assign head_o    = mem_r[rd_ptr_r];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage, pointer and occupancy update; push and pop together keep the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NumReq requesters. Requests
// pass through combinationally; a tag FIFO remembers who issued each
// accepted operation so results are routed back in acceptance order.
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int NumReq         = NumAluRequesters,
  parameter int MaxOutstanding = MaxAluOutstanding
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  num_t [NumReq-1:0]       req_left_i,
  input  num_t [NumReq-1:0]       req_right_i,
  input  op_t  [NumReq-1:0]       req_op_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output num_t                    rsp_result_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output num_t                    alu_left_o,
  output num_t                    alu_right_o,
  output op_t                     alu_op_o,
  output logic                    alu_in_valid_o,
  input  logic                    alu_in_ready_i,
  input  num_t                    alu_result_i,
  input  logic                    alu_out_valid_i,
  output logic                    alu_out_ready_o
);

  localparam int IdxW = idx_width(NumReq);
  typedef logic [IdxW-1:0] idx_t;

  idx_t rr_r;
  logic lock_r;
  idx_t lock_idx_r;

  idx_t grant_s;
  idx_t rr_next_s;
  idx_t head_s;
  logic accept_s;
  logic pop_s;
  logic tag_full_s;
  logic tag_empty_s;

  // Pick the requester: the locked one while stalled, otherwise the first
  // valid requester at or after the round-robin pointer.
  always_comb begin
    logic [IdxW:0] sum_s;
    idx_t          cand_s;
    logic          found_s;
    grant_s = rr_r;
    found_s = 1'b0;
    sum_s   = {(IdxW+1){1'b0}};
    cand_s  = {IdxW{1'b0}};
    if (lock_r) begin
      grant_s = lock_idx_r;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        sum_s = {1'b0, rr_r} + (IdxW+1)'(i);
        if (sum_s >= (IdxW+1)'(NumReq)) begin
          sum_s = sum_s - (IdxW+1)'(NumReq);
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[IdxW-1:0];
        if (!found_s && req_valid_i[cand_s]) begin
          grant_s = cand_s;
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Forward the granted operands and handshake; nothing issues while the tag
  // FIFO is full or reset is held.
  always_comb begin
    alu_left_o     = req_left_i[grant_s];
    alu_right_o    = req_right_i[grant_s];
    alu_op_o       = req_op_i[grant_s];
    alu_in_valid_o = rst_ni & (|req_valid_i) & ~tag_full_s;
    accept_s       = alu_in_valid_o & alu_in_ready_i;
    req_ready_o    = {NumReq{1'b0}};
    req_ready_o[grant_s] = accept_s;
    if (grant_s == idx_t'(NumReq - 1)) begin
      rr_next_s = {IdxW{1'b0}};
    end else begin
      rr_next_s = grant_s + idx_t'(1);
    end
  end

  // Route the ALU result to whoever owns the oldest outstanding tag.
  always_comb begin
    rsp_valid_o         = {NumReq{1'b0}};
    rsp_valid_o[head_s] = alu_out_valid_i & ~tag_empty_s;
    alu_out_ready_o     = rsp_ready_i[head_s] & ~tag_empty_s;
    pop_s               = alu_out_valid_i & alu_out_ready_o;
  end

  assign rsp_result_o = alu_result_i;

  // Round-robin pointer advance and grant lock across ALU backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r       <= {IdxW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdxW{1'b0}};
    end else if (accept_s) begin
      rr_r   <= rr_next_s;
      lock_r <= 1'b0;
    end else if (alu_in_valid_o) begin
      lock_r     <= 1'b1;
      lock_idx_r <= grant_s;
    end
  end

  tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept_s),
    .data_i  (grant_s),
    .pop_i   (pop_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s),
    .head_o  (head_s)
  );

  alu_arbiter_checker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_checker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lock_i      (lock_r),
    .lock_idx_i  (lock_idx_r),
    .req_valid_i (req_valid_i),
    .req_ready_i (req_ready_o)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter: the bench plays both the
// requesters and the ALU, predicts grants and routing from round-robin rules
// and a queue of outstanding operations, and a separate monitor checks each
// returned result against the queue.
module tb_alu_arbiter;
  import calc_pkg::*;

  localparam int N = 2;
  localparam int M = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  num_t [N-1:0]     req_left_i;
  num_t [N-1:0]     req_right_i;
  op_t  [N-1:0]     req_op_i;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  num_t             rsp_result_o;
  logic [N-1:0]     rsp_valid_o;
  logic [N-1:0]     rsp_ready_i;
  num_t             alu_left_o;
  num_t             alu_right_o;
  op_t              alu_op_o;
  logic             alu_in_valid_o;
  logic             alu_in_ready_i;
  num_t             alu_result_i;
  logic             alu_out_valid_i;
  logic             alu_out_ready_o;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.NumReq(N), .MaxOutstanding(M)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_left_i      (req_left_i),
    .req_right_i     (req_right_i),
    .req_op_i        (req_op_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .rsp_result_o    (rsp_result_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .alu_left_o      (alu_left_o),
    .alu_right_o     (alu_right_o),
    .alu_op_o        (alu_op_o),
    .alu_in_valid_o  (alu_in_valid_o),
    .alu_in_ready_i  (alu_in_ready_i),
    .alu_result_i    (alu_result_i),
    .alu_out_valid_i (alu_out_valid_i),
    .alu_out_ready_o (alu_out_ready_o)
  );

  typedef struct { int id; num_t res; } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];          // outstanding operations in acceptance order
  num_t alu_pipe[$];    // results the bench ALU still has to deliver

  bit   act [N];
  num_t m_left [N];
  num_t m_right [N];
  op_t  m_op [N];
  int   ptr;
  bit   hold;
  int   hold_idx;

  bit         c_in_ready;
  bit         c_out_valid;
  logic [N-1:0] c_rsp_ready;

  function automatic num_t ref_alu(input num_t a, input num_t b, input op_t op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // One clock of stimulus plus prediction; rnd arms requesters and ALU
  // controls randomly, otherwise the current control variables are used.
  task automatic step(input bit rnd);
    int   g;
    int   h;
    bit   any;
    bit   exp_valid;
    bit   exp_acc;
    bit   exp_pop;
    @(negedge clk_i);
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 99) < 55) begin
          act[i]     = 1'b1;
          m_left[i]  = num_t'($urandom);
          m_right[i] = num_t'($urandom);
          m_op[i]    = op_t'($urandom_range(0, 3));
        end
      end
      c_in_ready  = ($urandom_range(0, 99) < 65);
      c_out_valid = ($urandom_range(0, 99) < 60);
      c_rsp_ready = N'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = act[i];
      req_left_i[i]  = m_left[i];
      req_right_i[i] = m_right[i];
      req_op_i[i]    = m_op[i];
    end
    alu_in_ready_i  = c_in_ready;
    alu_out_valid_i = c_out_valid;
    alu_result_i    = (alu_pipe.size() > 0) ? alu_pipe[0] : num_t'($urandom);
    rsp_ready_i     = c_rsp_ready;
    #1;
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= act[i];
    g = -1;
    if (hold) g = hold_idx;
    else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (g < 0 && act[c]) g = c;
      end
    end
    exp_valid = any && (sb.size() < M);
    exp_acc   = exp_valid && c_in_ready;
    check("alu_in_valid", alu_in_valid_o, exp_valid);
    check("req_ready", req_ready_o, exp_acc ? (1 << g) : 0);
    if (exp_valid) begin
      check("alu_left", alu_left_o, m_left[g]);
      check("alu_right", alu_right_o, m_right[g]);
      check("alu_op", alu_op_o, m_op[g]);
    end
    h = (sb.size() > 0) ? sb[0].id : -1;
    exp_pop = (h >= 0) && c_out_valid && c_rsp_ready[h];
    check("alu_out_ready", alu_out_ready_o, (h >= 0) && c_rsp_ready[h]);
    check("rsp_valid", rsp_valid_o, ((h >= 0) && c_out_valid) ? (1 << h) : 0);
    if (exp_pop) void'(alu_pipe.pop_front());
    if (exp_acc) begin
      alu_pipe.push_back(ref_alu(alu_left_o, alu_right_o, alu_op_o));
      sb.push_back('{id: g, res: ref_alu(m_left[g], m_right[g], m_op[g])});
      act[g] = 1'b0;
      ptr    = (g + 1) % N;
      hold   = 1'b0;
    end else if (exp_valid) begin
      hold     = 1'b1;
      hold_idx = g;
    end
  endtask

  // Monitor: every delivered response must match the oldest outstanding entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni === 1'b1 && (|(rsp_valid_o & rsp_ready_i))) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid_o, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_valid_o, 1 << e.id);
          check("rsp_result", rsp_result_o, e.res);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; m_left[i] = 16'h0000; m_right[i] = 16'h0000; m_op[i] = OP_ADD;
    end
    ptr = 0; hold = 1'b0; hold_idx = 0;
    c_in_ready = 1'b0; c_out_valid = 1'b0; c_rsp_ready = {N{1'b1}};
    req_left_i = '{default: 16'h0000}; req_right_i = '{default: 16'h0000};
    req_op_i = '{default: OP_ADD}; alu_result_i = 16'h0000;

    // Reset with every input asserted: handshake outputs must stay low.
    rst_ni = 1'b0; req_valid_i = {N{1'b1}}; alu_in_ready_i = 1'b1;
    alu_out_valid_i = 1'b1; rsp_ready_i = {N{1'b1}};
    @(negedge clk_i); #1;
    check("rst_alu_in_valid", alu_in_valid_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_alu_out_ready", alu_out_ready_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; req_valid_i = {N{1'b0}}; alu_out_valid_i = 1'b0;

    // Single request: 5 + 3 from requester 0, result returned next cycle.
    act[0] = 1'b1; m_left[0] = 16'd5; m_right[0] = 16'd3; m_op[0] = OP_ADD;
    c_in_ready = 1'b1; c_out_valid = 1'b0; c_rsp_ready = {N{1'b1}};
    step(1'b0);
    c_out_valid = 1'b1;
    step(1'b0);

    // Fill the tag FIFO, see issue blocked, pop one (no bypass), then resume.
    c_out_valid = 1'b0;
    repeat (3) begin
      act[0] = 1'b1; act[1] = 1'b1;
      step(1'b0);
    end
    c_out_valid = 1'b1; c_rsp_ready = {N{1'b1}};
    step(1'b0);
    c_out_valid = 1'b0;
    step(1'b0);

    // Random traffic: contention, backpressure, stalls and ordering.
    repeat (3000) step(1'b1);

    // Drain everything, then build two outstanding operations.
    c_in_ready = 1'b1; c_out_valid = 1'b1; c_rsp_ready = {N{1'b1}};
    for (int k = 0; k < 40 && (sb.size() > 0 || act[0] || act[1]); k++) step(1'b0);
    c_out_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() < M; k++) begin
      act[0] = 1'b1; act[1] = 1'b1;
      step(1'b0);
    end
    n_tests++;
    if (sb.size() != M) begin
      n_fail++;
      $display("FAIL fill_timeout: got %0d outstanding expected %0d", sb.size(), M);
    end

    // Asynchronous reset mid-flight: outputs clear at once, tags discarded.
    #3;
    rst_ni = 1'b0; req_valid_i = {N{1'b1}}; alu_in_ready_i = 1'b1;
    alu_out_valid_i = 1'b1; rsp_ready_i = {N{1'b1}};
    #1;
    check("async_alu_in_valid", alu_in_valid_o, 0);
    check("async_req_ready", req_ready_o, 0);
    check("async_rsp_valid", rsp_valid_o, 0);
    check("async_alu_out_ready", alu_out_ready_o, 0);
    sb.delete(); alu_pipe.delete();
    act[0] = 1'b0; act[1] = 1'b0; ptr = 0; hold = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1; req_valid_i = {N{1'b0}}; alu_out_valid_i = 1'b0;
    c_in_ready = 1'b0; c_out_valid = 1'b1; c_rsp_ready = {N{1'b1}};
    repeat (2) step(1'b0);

    // Round-robin restarts at requester 0 after reset.
    c_out_valid = 1'b0; c_in_ready = 1'b1;
    act[0] = 1'b1; act[1] = 1'b1;
    step(1'b0);
    step(1'b0);

    @(negedge clk_i);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
